// File: rtl/lsu_subword_ctrl.sv
// lsu_subword_ctrl: RV32I load/store unit in front of a word-wide data memory.
// Handles sub-word loads (lane select + extend) and sub-word stores (read-modify-write).
module lsu_subword_ctrl #(
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, FMT, WR} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [2:0]        r_f3;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic [31:0]       r_load_data;
  logic              r_load_valid;
  logic              r_err;

  logic [MEM_AW-1:0] w_addr_nx;
  logic [31:0]       w_wdata_nx;
  logic              w_we_nx;
  logic [31:0]       w_ld_nx;
  logic              w_lv_nx;
  logic              w_err_nx;

  logic              w_accept;
  logic              w_legal;
  logic              w_misal;
  logic              w_bad;
  logic              w_sw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_fmt;
  logic [31:0]       w_merge;
  logic              w_unused;

  // Upper address bits wrap onto the memory; they are deliberately ignored.
  assign w_unused = ^req_addr[31:MEM_AW+2];

  assign req_ready  = (r_state == IDLE) & ~rst;
  assign w_accept   = req_valid & req_ready;
  assign load_valid = r_load_valid;
  assign load_data  = r_load_data;
  assign err        = r_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;

  // Decode legality and alignment of the incoming request.
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    if (req_we) begin
      unique case (req_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end else begin
      unique case (req_funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101:         w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      w_misal = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      w_misal = 1'b1;
  end

  assign w_bad = ~w_legal | w_misal;
  assign w_sw  = req_we & (req_funct3 == 3'b010);

  // Lane select / extension for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte  = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half  = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    w_fmt   = mem_rdata;
    w_merge = mem_rdata;
    unique case (r_f3)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_fmt = {24'd0, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_fmt = {16'd0, w_half};
      default: w_fmt = mem_rdata;
    endcase
    if (r_f3[1:0] == 2'b00)
      w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // Next-state and next registered outputs of the access sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_mem_addr;
    w_wdata_nx = r_mem_wdata;
    w_we_nx    = 1'b0;
    w_ld_nx    = r_load_data;
    w_lv_nx    = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_err_nx = 1'b1;
          end else begin
            w_addr_nx = req_addr[MEM_AW+1:2];
            if (w_sw) begin
              w_state_nx = WR;
              w_wdata_nx = req_wdata;
              w_we_nx    = 1'b1;
            end else begin
              w_state_nx = RD;
            end
          end
        end
      end
      RD: w_state_nx = FMT;
      FMT: begin
        if (r_we) begin
          w_state_nx = WR;
          w_wdata_nx = w_merge;
          w_we_nx    = 1'b1;
        end else begin
          w_state_nx = IDLE;
          w_ld_nx    = w_fmt;
          w_lv_nx    = 1'b1;
        end
      end
      WR: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Memory-side and result registers; reset clears a write in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mem_addr   <= w_addr_nx;
      r_mem_wdata  <= w_wdata_nx;
      r_mem_we     <= w_we_nx;
      r_load_data  <= w_ld_nx;
      r_load_valid <= w_lv_nx;
      r_err        <= w_err_nx;
    end
  end

  // Capture the request attributes needed by the later states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f3    <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_f3    <= req_funct3;
      r_lane  <= req_addr[1:0];
      r_wdata <= req_wdata;
      r_we    <= req_we;
    end
  end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// tb_lsu_subword_ctrl: directed table, corner sequences and random
// requests checked against a byte-level memory model.
module tb_lsu_subword_ctrl;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata = '0;

  lsu_subword_ctrl #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .load_valid(load_valid), .load_data(load_data),
    .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((int'(a[1:0]) % m_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input int lane);
    int n;
    logic [31:0] v;
    logic [31:0] msk;
    n = m_size(f3);
    v = w >> (8 * lane);
    if (n < 4) begin
      msk = (32'd1 << (8 * n)) - 32'd1;
      v = v & msk;
      if (!f3[2] && v[8*n-1]) v = v | ~msk;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3,
                                          input int lane, input logic [31:0] wd);
    for (int b = 0; b < m_size(f3); b++) w[8*(lane+b) +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  task automatic model_apply(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    if (we && !m_bad(we, f3, a))
      ref_mem[a[7:2]] = m_store(ref_mem[a[7:2]], f3, int'(a[1:0]), wd);
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic lv,
                         output logic [31:0] ld, output logic er, output int nwe,
                         output logic [AW-1:0] wa);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; lv = 0; ld = '0; er = 0; nwe = 0; wa = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin nwe++; wa = mem_addr; end
      if (load_valid) begin lv = 1; ld = load_data; end
      if (err) er = 1;
      if (req_ready) break;
    end
  endtask

  task automatic issue_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    int lat, nwe, elat;
    logic lv, er, bad;
    logic [31:0] ld;
    logic [AW-1:0] wa;
    bad = m_bad(we, f3, a);
    elat = bad ? 1 : (we ? ((f3 == 3'd2) ? 2 : 4) : 3);
    run_req(we, f3, a, wd, lat, lv, ld, er, nwe, wa);
    chk("rnd_lat", 32'(lat), 32'(elat));
    chk("rnd_err", 32'(er), 32'(bad));
    chk("rnd_lv", 32'(lv), 32'(!we && !bad));
    chk("rnd_nwe", 32'(nwe), 32'(we && !bad));
    if (!we && !bad) chk("rnd_ld", ld, m_load(ref_mem[a[7:2]], f3, int'(a[1:0])));
    if (we && !bad) chk("rnd_wa", 32'(wa), 32'(a[7:2]));
    model_apply(we, f3, a, wd);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        lv;
    logic [31:0] ld;
    logic        er;
    int          nwe;
    logic [5:0]  wa;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int lat, nwe, c;
    logic lv, er, got;
    logic [31:0] ld;
    logic [AW-1:0] wa;
    logic [2:0] f3;
    logic we;

    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    tbl.push_back('{1, 3'd2, 32'h10,  32'hDEADBEEF, 2, 0, 32'h0, 0, 1, 6'd4});
    tbl.push_back('{0, 3'd2, 32'h10,  32'h0,        3, 1, 32'hDEADBEEF, 0, 0, 6'd0});
    tbl.push_back('{1, 3'd2, 32'h20,  32'h11223344, 2, 0, 32'h0, 0, 1, 6'd8});
    tbl.push_back('{1, 3'd0, 32'h21,  32'h123456AA, 4, 0, 32'h0, 0, 1, 6'd8});
    tbl.push_back('{0, 3'd2, 32'h20,  32'h0,        3, 1, 32'h1122AA44, 0, 0, 6'd0});
    tbl.push_back('{1, 3'd2, 32'h30,  32'h80F07F01, 2, 0, 32'h0, 0, 1, 6'd12});
    tbl.push_back('{0, 3'd0, 32'h32,  32'h0,        3, 1, 32'hFFFFFFF0, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd4, 32'h32,  32'h0,        3, 1, 32'h000000F0, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd1, 32'h32,  32'h0,        3, 1, 32'hFFFF80F0, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd5, 32'h32,  32'h0,        3, 1, 32'h000080F0, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd0, 32'h30,  32'h0,        3, 1, 32'h00000001, 0, 0, 6'd0});
    tbl.push_back('{1, 3'd1, 32'h31,  32'h0000BEEF, 1, 0, 32'h0, 1, 0, 6'd0});
    tbl.push_back('{0, 3'd2, 32'h22,  32'h0,        1, 0, 32'h0, 1, 0, 6'd0});
    tbl.push_back('{0, 3'd3, 32'h20,  32'h0,        1, 0, 32'h0, 1, 0, 6'd0});
    tbl.push_back('{1, 3'd4, 32'h20,  32'h55555555, 1, 0, 32'h0, 1, 0, 6'd0});
    tbl.push_back('{0, 3'd1, 32'h13,  32'h0,        1, 0, 32'h0, 1, 0, 6'd0});
    tbl.push_back('{0, 3'd2, 32'h20,  32'h0,        3, 1, 32'h1122AA44, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd2, 32'h30,  32'h0,        3, 1, 32'h80F07F01, 0, 0, 6'd0});
    tbl.push_back('{1, 3'd1, 32'h12,  32'h5555CAFE, 4, 0, 32'h0, 0, 1, 6'd4});
    tbl.push_back('{0, 3'd2, 32'h10,  32'h0,        3, 1, 32'hCAFEBEEF, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd5, 32'h12,  32'h0,        3, 1, 32'h0000CAFE, 0, 0, 6'd0});
    tbl.push_back('{0, 3'd1, 32'h12,  32'h0,        3, 1, 32'hFFFFCAFE, 0, 0, 6'd0});
    tbl.push_back('{1, 3'd2, 32'h114, 32'h0BADF00D, 2, 0, 32'h0, 0, 1, 6'd5});
    tbl.push_back('{0, 3'd2, 32'h14,  32'h0,        3, 1, 32'h0BADF00D, 0, 0, 6'd0});

    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_lv", 32'(load_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("idle_quiet", {29'd0, load_valid, err, mem_we}, 32'h0);

    // directed table
    foreach (tbl[i]) begin
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, lat, lv, ld, er, nwe, wa);
      chk($sformatf("t%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("t%0d_lv", i), 32'(lv), 32'(tbl[i].lv));
      chk($sformatf("t%0d_err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("t%0d_nwe", i), 32'(nwe), 32'(tbl[i].nwe));
      if (tbl[i].lv) chk($sformatf("t%0d_ld", i), ld, tbl[i].ld);
      if (tbl[i].nwe != 0) chk($sformatf("t%0d_wa", i), 32'(wa), 32'(tbl[i].wa));
      model_apply(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
    end

    // reset during the WR cycle of an SB
    issue_model(1'b1, 3'd2, 32'h40, 32'h11111111);
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h41; req_wdata = 32'h22;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_wr", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_we_drop", 32'(mem_we), 32'h0);
    chk("abort_ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready_back", 32'(req_ready), 32'h1);
    @(negedge clk);
    issue_model(1'b0, 3'd2, 32'h40, 32'h0);
    chk("abort_mem_unchanged", ref_mem[16], 32'h11111111);

    // LW followed by a held SW with a wrapping address
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = '0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'hFFFFFF28; req_wdata = 32'h5A5A1234;
    c = 0; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      c++;
      if (load_valid) got = 1;
    end
    chk("b2b_lv_lat", 32'(c), 32'd3);
    chk("b2b_ready_with_lv", 32'(req_ready), 32'h1);
    chk("b2b_ld", load_data, 32'h1122AA44);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_sw_we", 32'(mem_we), 32'h1);
    chk("b2b_sw_wrap_addr", 32'(mem_addr), 32'd10);
    chk("b2b_sw_data", mem_wdata, 32'h5A5A1234);
    @(negedge clk);
    chk("b2b_sw_done", 32'(req_ready), 32'h1);
    model_apply(1'b1, 3'd2, 32'hFFFFFF28, 32'h5A5A1234);
    issue_model(1'b0, 3'd2, 32'h28, 32'h0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else f3 = (f3 == 3'd3 || f3 > 3'd5) ? 3'd2 : f3;
      end
      issue_model(we, f3, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("rnd_idle_quiet", {29'd0, load_valid, err, mem_we}, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
